serial_word_subtractor: RTL and testbench
=========================================

SERIAL_WORD_SUBTRACTOR -- requirements
Module: serial_word_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand, result and shift-count width (legal range 2..32).
REQ-002 CLK  input  1  Sole clock. All state SHALL update on its rising edge.
REQ-003 RST  input  1  Reset, synchronous and active-low.
REQ-004 START  input  1  Request to subtract; sampled only in IDLE.
REQ-005 A  input  WIDTH  Minuend; captured on the accepting edge.
REQ-006 B  input  WIDTH  Subtrahend; captured on the accepting edge.
REQ-007 BUSY  output  1  High while an operation is in progress (SHIFT or FIN).
REQ-008 DONE  output  1  One-cycle pulse; DIFF and BOUT are valid.
REQ-009 DIFF  output  WIDTH  Result A-B modulo 2^WIDTH.
REQ-010 BOUT  output  1  Final borrow; 1 iff A<B (unsigned).
REQ-011 SOUT  output  1  Difference bit produced on the current SHIFT edge, LSB first; for monitoring.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-013 IDLE with START=1 at an edge: the block SHALL load A and B into shift registers, clear the borrow and the bit counter, and move to SHIFT.
REQ-014 IDLE with START=0: the block SHALL hold its state, and DIFF and BOUT SHALL keep their last values.
REQ-015 Each SHIFT edge SHALL compute d=a0^b0^br and br'=(~a0&b0)|(~(a0^b0)&br) from the operand LSBs and the borrow.
REQ-016 On each SHIFT edge, the block SHALL shift both operands right, shift d into the result MSB, and increment the counter.
REQ-017 After exactly WIDTH SHIFT edges (counter = WIDTH-1 at the edge), the block SHALL move to FIN.
REQ-018 In FIN, DONE=1 for exactly one cycle, with DIFF holding all WIDTH result bits and BOUT equal to the final borrow; the next edge SHALL move to IDLE.
REQ-019 Latency SHALL be: START sampled at edge 0, DONE high in the cycle after edge WIDTH, and the block back in IDLE after edge WIDTH+1.
REQ-020 BUSY SHALL be 1 in SHIFT and FIN and 0 in IDLE.
REQ-021 START SHALL be ignored in SHIFT and FIN, including in the DONE cycle; there is no queuing.
REQ-022 The block SHALL accept back-to-back operations: START held high SHALL be accepted again on the first IDLE edge.
REQ-023 DIFF and BOUT SHALL be updated only during SHIFT.
REQ-024 DIFF and BOUT SHALL remain stable from FIN until the next accepted START plus one edge.
REQ-025 A and B changing after the accepting edge SHALL have no effect on the result.
REQ-026 Arithmetic SHALL be unsigned, with wrap-around modulo 2^WIDTH; A=B SHALL give DIFF=0 and BOUT=0.

Reset
REQ-027 RST=0 at an edge SHALL force IDLE and clear to zero the counter, borrow, operand registers, DIFF, BOUT, SOUT, DONE and BUSY.
REQ-028 RST SHALL take priority over every other condition, including START.
REQ-029 RST during SHIFT or FIN SHALL abort the operation with no DONE pulse; a START is accepted on the first edge with RST=1.

Structure
REQ-030 The state encoding (IDLE=2'd0, SHIFT=2'd1, FIN=2'd2) and the default WIDTH constant SHALL live in the shared package serial_arith_pkg.
REQ-031 The one-bit borrow cell SHALL be the sub-module serial_bit_sub (inputs A, B, BIN; outputs D, BOUT; purely combinational).
REQ-032 The borrow flop SHALL reside in serial_word_subtractor.

Verification (WIDTH=8)
REQ-033 Basic subtract: A=8'd5, B=8'd3, START one cycle. Required: DIFF=8'h02, BOUT=0, DONE in cycle 9 after the accepting edge, SOUT sequence 0,1,0,0,0,0,0,0.
REQ-034 Underflow: A=8'h00, B=8'h01. Required: DIFF=8'hFF, BOUT=1. Then A=8'h03, B=8'h05. Required: DIFF=8'hFE, BOUT=1.
REQ-035 Equal and extreme operands: A=B=8'hA5. Required: DIFF=0, BOUT=0. Then A=8'hFF, B=8'h00. Required: DIFF=8'hFF, BOUT=0.
REQ-036 Busy rejection: pulse START with A=1, B=1 at SHIFT cycle 3. Required: no restart, result of the first operation unchanged, exactly one DONE pulse.
REQ-037 Reset mid-operation: RST=0 at SHIFT cycle 4. Required: all outputs 0 next cycle, no DONE; a new START of 8'd10-8'd4 gives DIFF=8'h06.
REQ-038 Back-to-back: START held high for three operations. Required: DONE pulses spaced exactly WIDTH+2 cycles apart, each with the correct DIFF.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encoding and default width for the serial arithmetic blocks
package serial_arith_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_e;
endpackage

// File: rtl/serial_bit_sub.sv
// serial_bit_sub: one-bit full subtractor cell (D = A - B - BIN)
module serial_bit_sub (
   input  logic A,
   input  logic B,
   input  logic BIN,
   output logic D,
   output logic BOUT
);
   assign D    = A ^ B ^ BIN;
   assign BOUT = (~A & B) | (~(A ^ B) & BIN);
endmodule

// File: rtl/serial_word_subtractor.sv
// serial_word_subtractor: bit-serial unsigned A-B, LSB first, one result bit per clock
module serial_word_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT,
   output logic             SOUT
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);
   state_e state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, cnt_q, cnt_d;
   logic br_q, br_d, bout_q, bout_d, sout_q, sout_d, d, br_next;
   serial_bit_sub u_bit (
      .A   (a_q[0]),
      .B   (b_q[0]),
      .BIN (br_q),
      .D   (d),
      .BOUT(br_next)
   );
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         sout_q  <= sout_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE)  ? (START ? SHIFT : IDLE) :
                (state_q == SHIFT) ? ((cnt_q == LAST) ? FIN : SHIFT) : IDLE;
   end
   // Results and borrow only move on SHIFT edges, so they hold through FIN and IDLE.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      diff_d = diff_q;
      cnt_d  = cnt_q;
      br_d   = br_q;
      bout_d = bout_q;
      sout_d = sout_q;
      if (state_q == IDLE && START) begin
         a_d   = A;
         b_d   = B;
         br_d  = 1'b0;
         cnt_d = '0;
      end else if (state_q == SHIFT) begin
         a_d    = a_q >> 1;
         b_d    = b_q >> 1;
         diff_d = {d, diff_q[WIDTH-1:1]};
         cnt_d  = cnt_q + 1'b1;
         br_d   = br_next;
         bout_d = br_next;
         sout_d = d;
      end
   end
   always_comb begin
      BUSY = (state_q != IDLE);
      DONE = (state_q == FIN);
   end
   assign DIFF = diff_q;
   assign BOUT = bout_q;
   assign SOUT = sout_q;
endmodule

// File: tb/tb_serial_word_subtractor.sv
// tb_serial_word_subtractor: directed vectors with a queue scoreboard checked on every DONE
module tb_serial_word_subtractor;
   localparam int W = 8;
   logic CLK, RST, START, BUSY, DONE, BOUT, SOUT;
   logic [W-1:0] A, B, DIFF;
   logic [W:0] exp_q[$];
   int done_cyc[$];
   int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
   serial_word_subtractor #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BOUT(BOUT), .SOUT(SOUT)
   );
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge CLK) begin
      if (DONE === 1'b1) begin
         done_cnt++;
         done_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: DONE at cycle %0d with nothing expected", cyc);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("diff", DIFF, e[W-1:0]);
            check("bout", BOUT, e[W]);
         end
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (DONE !== 1'b1 && n < 20);
   endtask
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb);
      int n;
      A = a;
      B = b;
      START = 1'b1;
      exp_q.push_back({eb, ed});
      tick();
      START = 1'b0;
      A = ~a;
      B = ~b;
      wait_done(n);
      check("latency", n, W);
      tick();
      check("idle_busy", BUSY, 0);
   endtask
   initial begin
      logic [W-1:0] sout_exp;
      int n, snap;
      RST = 1'b0;
      START = 1'b0;
      A = '0;
      B = '0;
      tick(2);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_diff", DIFF, 0);
      check("rst_bout", BOUT, 0);
      check("rst_sout", SOUT, 0);
      RST = 1'b1;
      tick();
      // 5 - 3 with per-edge SOUT and DONE timing
      sout_exp = 8'b0000_0010;
      A = 8'd5;
      B = 8'd3;
      START = 1'b1;
      exp_q.push_back({1'b0, 8'h02});
      tick();
      START = 1'b0;
      check("accept_busy", BUSY, 1);
      for (int k = 1; k <= W; k++) begin
         tick();
         check($sformatf("sout_%0d", k), SOUT, sout_exp[k-1]);
         check($sformatf("done_at_%0d", k), DONE, (k == W) ? 1 : 0);
      end
      tick();
      check("basic_idle_busy", BUSY, 0);
      check("basic_idle_done", DONE, 0);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1);
      run_op(8'h03, 8'h05, 8'hFE, 1'b1);
      run_op(8'hA5, 8'hA5, 8'h00, 1'b0);
      run_op(8'hFF, 8'h00, 8'hFF, 1'b0);
      // START pulsed mid-operation must be ignored
      snap = done_cnt;
      A = 8'd20;
      B = 8'd7;
      START = 1'b1;
      exp_q.push_back({1'b0, 8'h0D});
      tick();
      START = 1'b0;
      tick(2);
      A = 8'd1;
      B = 8'd1;
      START = 1'b1;
      tick();
      START = 1'b0;
      wait_done(n);
      check("busy_latency", n, 5);
      tick(3);
      check("busy_one_done", done_cnt - snap, 1);
      check("busy_idle", BUSY, 0);
      check("busy_hold_diff", DIFF, 8'h0D);
      check("busy_hold_bout", BOUT, 0);
      // reset mid-operation aborts with no DONE, even with START high
      snap = done_cnt;
      A = 8'h33;
      B = 8'h11;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick(4);
      RST = 1'b0;
      START = 1'b1;
      tick();
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      check("abort_diff", DIFF, 0);
      check("abort_bout", BOUT, 0);
      check("abort_sout", SOUT, 0);
      START = 1'b0;
      RST = 1'b1;
      tick(12);
      check("abort_no_done", done_cnt - snap, 0);
      check("abort_idle", BUSY, 0);
      run_op(8'd10, 8'd4, 8'h06, 1'b0);
      // three back-to-back operations with START held high
      snap = done_cyc.size();
      A = 8'd9;
      B = 8'd2;
      START = 1'b1;
      exp_q.push_back({1'b0, 8'h07});
      exp_q.push_back({1'b1, 8'hF9});
      exp_q.push_back({1'b0, 8'h64});
      tick();
      A = 8'd2;
      B = 8'd9;
      tick(W + 2);
      A = 8'd200;
      B = 8'd100;
      tick(W + 2);
      START = 1'b0;
      A = 8'h00;
      B = 8'h00;
      tick(W + 4);
      check("b2b_count", done_cyc.size() - snap, 3);
      if (done_cyc.size() - snap == 3) begin
         check("b2b_gap1", done_cyc[snap+1] - done_cyc[snap], W + 2);
         check("b2b_gap2", done_cyc[snap+2] - done_cyc[snap+1], W + 2);
      end
      check("b2b_idle", BUSY, 0);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
